// File: rtl/mdu_ctrl_if.sv
// E-stage command/read bus between the pipeline and the multiply/divide controller.
interface mdu_ctrl_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  op;
  logic        start;
  logic        hilo_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (output A, B, op, start, hilo_sel, input busy, hi, lo, rd_data);
  modport slave  (input A, B, op, start, hilo_sel, output busy, hi, lo, rd_data);
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div sequencer owning HI/LO; the result is computed at issue and
// held pending until the modelled latency expires.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  m
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic [31:0]    hi_q, lo_q;
  logic [63:0]    pend_q;
  logic           pend_wr_q;

  logic signed [63:0] mul_s;
  logic [63:0]        mul_u;
  logic [31:0]        a_mag, b_mag, bs_div, uq, ur, quo_s, rem_s;
  logic [31:0]        bu_div, quo_u, rem_u;
  logic               q_neg;

  assign mul_s = $signed({{32{m.A[31]}}, m.A}) * $signed({{32{m.B[31]}}, m.B});
  assign mul_u = {32'd0, m.A} * {32'd0, m.B};

  // Signed divide via magnitudes so INT_MIN / -1 wraps to INT_MIN without a trap.
  assign a_mag  = m.A[31] ? (32'd0 - m.A) : m.A;
  assign b_mag  = m.B[31] ? (32'd0 - m.B) : m.B;
  assign bs_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign uq     = a_mag / bs_div;
  assign ur     = a_mag % bs_div;
  assign q_neg  = m.A[31] ^ m.B[31];
  assign quo_s  = q_neg   ? (32'd0 - uq) : uq;
  assign rem_s  = m.A[31] ? (32'd0 - ur) : ur;

  assign bu_div = (m.B == 32'd0) ? 32'd1 : m.B;
  assign quo_u  = m.A / bu_div;
  assign rem_u  = m.A % bu_div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (m.start) begin
          case (m.op)
            OP_MULT, OP_MULTU: begin
              pend_q    <= (m.op == OP_MULT) ? mul_s : mul_u;
              pend_wr_q <= 1'b1;
              cnt_q     <= MC;
              state_q   <= RUN;
              busy_q    <= 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              pend_q    <= (m.op == OP_DIV) ? {rem_s, quo_s} : {rem_u, quo_u};
              pend_wr_q <= (m.B != 32'd0);  // divide by zero leaves HI/LO untouched
              cnt_q     <= DC;
              state_q   <= RUN;
              busy_q    <= 1'b1;
            end
            OP_MTHI: hi_q <= m.A;
            OP_MTLO: lo_q <= m.A;
            default: ;
          endcase
        end
        RUN: begin
          if (cnt_q == CW'(1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (pend_wr_q) {hi_q, lo_q} <= pend_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m.busy    = busy_q;
  assign m.hi      = hi_q;
  assign m.lo      = lo_q;
  assign m.rd_data = m.hilo_sel ? hi_q : lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO pushed at issue, popped when busy drops.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset;
  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .m(bus));

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] sb[$];
  logic [31:0] mh, ml;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mulref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv;
    if (sgn) begin
      sa  = $signed({{32{a[31]}}, a});
      sbv = $signed({{32{b[31]}}, b});
      return sa * sbv;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] res, input bit wr,
                        input int n, input bit inject);
    int cyc;
    logic [63:0] e;
    sb.push_back(wr ? res : {mh, ml});
    @(negedge clk);
    bus.A = a; bus.B = b; bus.op = o; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd0; bus.A = $urandom; bus.B = $urandom;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      bus.hilo_sel = cyc[0];
      #1 chk({tag, "_rd_old"}, {32'd0, bus.rd_data}, {32'd0, cyc[0] ? mh : ml});
      if (inject && cyc == 2) begin
        bus.op = 3'd6; bus.A = 32'hDEADBEEF; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0; bus.op = 3'd0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, "_busylen"}, 64'(cyc), 64'(n));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, e[63:32]});
      chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, e[31:0]});
      mh = e[63:32]; ml = e[31:0];
    end
    bus.hilo_sel = 1'b1;
    #1 chk({tag, "_rd_hi"}, {32'd0, bus.rd_data}, {32'd0, mh});
  endtask

  task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    bus.A = a; bus.op = o; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd0;
    if (o == 3'd5) mh = a;
    if (o == 3'd6) ml = a;
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, {mh, ml});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  ro;
    bus.A = '0; bus.B = '0; bus.op = '0; bus.start = 1'b0; bus.hilo_sel = 1'b0;
    mh = '0; ml = '0;
    reset = 1'b1;
    #12;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_mt("mthi", 3'd5, 32'h12345678);
    run_mt("mtlo", 3'd6, 32'h9ABCDEF0);
    bus.hilo_sel = 1'b0;
    #1 chk("rd_lo", {32'd0, bus.rd_data}, {32'd0, ml});
    run_mt("op_none", 3'd0, 32'h11111111);
    run_mt("op_rsvd", 3'd7, 32'h22222222);

    run_md("divu0", 3'd4, 32'd5, 32'd0, 64'd0, 1'b0, 10, 1'b0);
    run_md("div0", 3'd3, 32'hFFFFFFF9, 32'd0, 64'd0, 1'b0, 10, 1'b0);
    run_md("mult", 3'd1, 32'hFFFFFFFF, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFE}, 1'b1, 5, 1'b0);
    run_md("multu", 3'd2, 32'hFFFFFFFF, 32'h2, {32'h00000001, 32'hFFFFFFFE}, 1'b1, 5, 1'b0);
    run_md("div", 3'd3, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b1, 10, 1'b0);
    run_md("divu", 3'd4, 32'd7, 32'd2, {32'd1, 32'd3}, 1'b1, 10, 1'b0);
    run_md("div_negb", 3'd3, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1'b1, 10, 1'b0);
    run_md("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b1, 10, 1'b0);
    run_md("divu_big", 3'd4, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC}, 1'b1, 10, 1'b0);
    run_md("ign_start", 3'd2, 32'h00012345, 32'h00000100,
           mulref(1'b0, 32'h00012345, 32'h00000100), 1'b1, 5, 1'b1);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      ro = (i % 2 == 0) ? 3'd1 : 3'd2;
      run_md("rnd_mul", ro, ra, rb, mulref(ro == 3'd1, ra, rb), 1'b1, 5, 1'b0);
    end

    // Reset landing in the middle of a multiply.
    @(negedge clk);
    bus.A = 32'd3; bus.B = 32'd4; bus.op = 3'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd0;
    chk("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    mh = '0; ml = '0;
    @(negedge clk);
    reset = 1'b0;
    chk("postrst_idle", {63'd0, bus.busy}, 64'd0);
    run_md("postrst_mult", 3'd1, 32'd3, 32'hFFFFFFFC, {32'hFFFFFFFF, 32'hFFFFFFF4}, 1'b1, 5, 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
